// File: rtl/blink_stream_feeder.sv
// Streaming front/back-end for the combinational Blink-64 core: holds the key, stages
// one block (P, per-block tweak, enc) towards the core and returns C with a last flag.
module blink_stream_feeder #(
  parameter int CORE_LAT = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_we,
  input  logic [447:0]     key_in,
  input  logic             start,
  input  logic             enc_mode,
  input  logic [63:0]      tweak_base,
  input  logic [CNT_W-1:0] num_blocks,
  input  logic             abort,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [63:0]      s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [63:0]      m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic             core_enc,
  output logic [447:0]     core_K0,
  output logic [63:0]      core_P,
  output logic [63:0]      core_T,
  input  logic [63:0]      core_C,
  output logic [1:0]       dbg_state_o
);

  localparam int WAIT_W = (CORE_LAT > 0) ? $clog2(CORE_LAT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [447:0]       key_q;
  logic               enc_q;
  logic [63:0]        tweak_q;
  logic [CNT_W-1:0]   remain_q;
  logic [63:0]        p_data_q, p_tweak_q;
  logic               p_vld_q, p_last_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [63:0]        m_data_q;
  logic               m_valid_q, m_last_q, done_q;
  logic               s_hs, m_hs, p_move, last_in;

  // Both streams transfer a beat on a rising edge where valid and ready are both high;
  // a source keeps valid and data stable until that edge, ready may change freely.
  assign s_hs    = s_valid & s_ready;
  assign m_hs    = m_valid_q & m_ready;
  assign p_move  = p_vld_q & (wait_q == '0) & (~m_valid_q | m_ready);
  assign last_in = (remain_q == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start && (num_blocks != '0)) state_d = ST_RUN;
        ST_RUN:   if (s_hs && last_in)             state_d = ST_DRAIN;
        ST_DRAIN: if (m_hs && m_last_q)            state_d = ST_IDLE;
        default:                                   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    s_ready     = (state_q == ST_RUN) && (remain_q != '0) && (!p_vld_q || p_move);
    dbg_state_o = state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q     <= '0;
      enc_q     <= 1'b1;
      tweak_q   <= '0;
      remain_q  <= '0;
      p_data_q  <= '0;
      p_tweak_q <= '0;
      p_vld_q   <= 1'b0;
      p_last_q  <= 1'b0;
      wait_q    <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // The key is only writable between messages so a running message never sees it change.
      if ((state_q == ST_IDLE) && key_we) key_q <= key_in;
      if ((state_q == ST_IDLE) && start && !abort) begin
        enc_q    <= enc_mode;
        tweak_q  <= tweak_base;
        remain_q <= num_blocks;
        if (num_blocks == '0) done_q <= 1'b1;
      end
      if (abort) begin
        p_vld_q   <= 1'b0;
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
        wait_q    <= '0;
      end else begin
        if (s_hs) begin
          p_data_q  <= s_data;
          p_tweak_q <= tweak_q;
          tweak_q   <= tweak_q + 64'd1;
          remain_q  <= remain_q - CNT_W'(1);
          p_last_q  <= last_in;
          p_vld_q   <= 1'b1;
          wait_q    <= WAIT_W'(CORE_LAT);
        end else begin
          if (p_move)        p_vld_q <= 1'b0;
          if (wait_q != '0)  wait_q  <= wait_q - WAIT_W'(1);
        end
        if (p_move) begin
          m_data_q  <= core_C;
          m_last_q  <= p_last_q;
          m_valid_q <= 1'b1;
        end else if (m_hs) begin
          m_valid_q <= 1'b0;
        end
        if (m_hs && m_last_q) done_q <= 1'b1;
      end
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_last   = m_last_q;
  assign done     = done_q;
  assign core_enc = enc_q;
  assign core_K0  = key_q;
  assign core_P   = p_data_q;
  assign core_T   = p_tweak_q;

endmodule
